// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port, variable-latency SRAM between an instruction-fetch
//   requester (read-only) and a data requester (read/write). A four-state grant
//   FSM (IDLE, GRANT_I, GRANT_D, RELEASE) arbitrates round-robin. While a port
//   is granted, its address/data/byte enables pass straight through to the RAM
//   until ram_busy drops. Every completion is followed by one RELEASE cycle so
//   the RAM always sees the enables fall between transactions.
//
//   Optional feature macro: RAM_ARB_TIMEOUT_EN
//     Adds a watchdog counter and the timeout_err output. If the granted access
//     stays busy for TIMEOUT cycles, the transaction is ended with error data
//     0xBAD1_BAD1 (replicated) and a one-cycle timeout_err pulse.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   iren, iaddr        instruction read request and word address
//   irdata, ibusy      instruction read data; ibusy=0 marks completion
//   dren, dwen         data read / write request (both high = write)
//   daddr, dwdata      data word address and write data
//   dbyte_en           data byte enables
//   drdata, dbusy      data read data; dbusy=0 marks completion
//   ram_addr/wdata/byte_en/ren/wen   RAM request side
//   ram_rdata, ram_busy              RAM response side (ram_busy=0 = done)
//   timeout_err        watchdog abort pulse (RAM_ARB_TIMEOUT_EN only)

module ram_port_arbiter #(
  parameter int N_BYTES   = 4,
  parameter int ADDR_BITS = 13,
  parameter int N_BITS    = N_BYTES * 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 iren,
  input  logic [ADDR_BITS-1:0] iaddr,
  output logic [N_BITS-1:0]    irdata,
  output logic                 ibusy,
  input  logic                 dren,
  input  logic                 dwen,
  input  logic [ADDR_BITS-1:0] daddr,
  input  logic [N_BITS-1:0]    dwdata,
  input  logic [N_BYTES-1:0]   dbyte_en,
  output logic [N_BITS-1:0]    drdata,
  output logic                 dbusy,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N_BITS-1:0]    ram_wdata,
  output logic [N_BYTES-1:0]   ram_byte_en,
  output logic                 ram_ren,
  output logic                 ram_wen,
  input  logic [N_BITS-1:0]    ram_rdata,
  input  logic                 ram_busy
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_next;
  // 1 = the data port held the most recent grant
  logic   last_grant_d, last_grant_d_next;

  logic ireq, dreq, granted_req, tmo;

  assign ireq = iren;
  assign dreq = dren | dwen;

  always_comb begin
    granted_req = 1'b0;
    if (state == GRANT_I) granted_req = ireq;
    else if (state == GRANT_D) granted_req = dreq;
  end

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

  logic [CW-1:0] wd_cnt;

  // Error data: 0xBAD1_BAD1 repeated over the whole word, byte by byte
  function automatic logic [N_BITS-1:0] bad_pattern();
    logic [N_BITS-1:0] p;
    p = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      p[b*8 +: 8] = (b % 2 == 0) ? 8'hD1 : 8'hBA;
    end
    return p;
  endfunction

  // Counts granted cycles in which the RAM is still busy; cleared outside grants
  // so every new grant starts from zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt <= '0;
    end else if (state == GRANT_I || state == GRANT_D) begin
      if (ram_busy) wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  // A dropped request (abort) takes priority over the watchdog
  assign tmo         = granted_req && ram_busy && (wd_cnt == TIMEOUT_VAL);
  assign timeout_err = tmo;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state        <= state_next;
      last_grant_d <= last_grant_d_next;
    end
  end

  always_comb begin
    state_next        = state;
    last_grant_d_next = last_grant_d;
    ram_addr          = '0;
    ram_wdata         = '0;
    ram_byte_en       = '0;
    ram_ren           = 1'b0;
    ram_wen           = 1'b0;
    ibusy             = 1'b1;
    dbusy             = 1'b1;
    irdata            = '0;
    drdata            = '0;

    unique case (state)
      IDLE: begin
        // With both requesting, the port that did not hold the last grant wins
        if (ireq && (!dreq || last_grant_d)) begin
          state_next        = GRANT_I;
          last_grant_d_next = 1'b0;
        end else if (dreq) begin
          state_next        = GRANT_D;
          last_grant_d_next = 1'b1;
        end
      end

      GRANT_I: begin
        ram_addr    = iaddr;
        ram_byte_en = '1;
        irdata      = ram_rdata;
        if (!ireq) begin
          state_next = IDLE;
        end else begin
          ram_ren = 1'b1;
          if (!ram_busy || tmo) begin
            ibusy      = 1'b0;
            state_next = RELEASE;
          end
        end
`ifdef RAM_ARB_TIMEOUT_EN
        if (tmo) irdata = bad_pattern();
`endif
      end

      GRANT_D: begin
        ram_addr    = daddr;
        ram_wdata   = dwdata;
        ram_byte_en = dbyte_en;
        drdata      = ram_rdata;
        if (!dreq) begin
          state_next = IDLE;
        end else begin
          // A simultaneous read and write request is served as a write
          if (dwen) ram_wen = 1'b1;
          else      ram_ren = 1'b1;
          if (!ram_busy || tmo) begin
            dbusy      = 1'b0;
            state_next = RELEASE;
          end
        end
`ifdef RAM_ARB_TIMEOUT_EN
        if (tmo) drdata = bad_pattern();
`endif
      end

      RELEASE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int TO = 8;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iren, dren, dwen;
  logic [12:0] iaddr, daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbyte_en;
  logic [31:0] irdata, drdata;
  logic        ibusy, dbusy;
  logic [12:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_byte_en;
  logic        ram_ren, ram_wen, ram_busy;
  logic        timeout_err;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(
    .N_BYTES(4), .ADDR_BITS(13), .N_BITS(32), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iren(iren), .iaddr(iaddr), .irdata(irdata), .ibusy(ibusy),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dwdata(dwdata),
    .dbyte_en(dbyte_en), .drdata(drdata), .dbusy(dbusy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byte_en(ram_byte_en),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_rdata(ram_rdata),
    .ram_busy(ram_busy)
`ifdef RAM_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

`ifndef RAM_ARB_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  // RAM model: busy for 'lat' cycles of a held access, writes commit on done
  logic [31:0] mem [0:8191];
  bit          mem_ready = 1'b0;
  int          lat = 0;
  int          lat_cnt = 0;
  bit          force_busy = 1'b0;
  int          wr_commits = 0;

  assign ram_busy  = force_busy || ((ram_ren || ram_wen) && (lat_cnt < lat));
  assign ram_rdata = mem[ram_addr];

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int a = 0; a < 8192; a++) mem[a] <= 32'hC0DE0000 | a;
      mem[16]   <= 32'hDEADBEEF;
      mem[32]   <= 32'hAAAAAAAA;
      mem_ready <= 1'b1;
    end else if (ram_wen && !ram_busy) begin
      for (int b = 0; b < 4; b++)
        if (ram_byte_en[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      wr_commits <= wr_commits + 1;
    end
    if ((ram_ren || ram_wen) && ram_busy) lat_cnt <= lat_cnt + 1;
    else                                  lat_cnt <= 0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the RAM, how many forced idle cycles
  // remain before a new grant may be decided, and who has priority next.
  int          m_owner = 0;   // 0 none, 1 instruction, 2 data
  int          m_gap = 0;
  bit          m_pref_i = 1'b1;
  int          m_tcnt = 0;
  bit          m_ireq, m_dreq, m_tmo, m_req;
  logic [12:0] e_addr;
  logic [31:0] e_wdata, e_ird, e_drd;
  logic [3:0]  e_be;
  logic        e_ren, e_wen, e_ib, e_db, e_tmo;

  always @(negedge CLK) begin
    e_addr = '0; e_wdata = '0; e_be = '0; e_ren = 0; e_wen = 0;
    e_ib = 1; e_db = 1; e_ird = '0; e_drd = '0; e_tmo = 0; m_tmo = 0;
    m_ireq = iren;
    m_dreq = dren | dwen;
    if (nRST) begin
      if (m_owner == 1) begin
        e_addr = iaddr; e_be = 4'hF; e_ird = ram_rdata;
        m_tmo = TMO_EN && m_ireq && ram_busy && (m_tcnt == TO);
        if (m_ireq) begin
          e_ren = 1;
          if (!ram_busy || m_tmo) e_ib = 0;
        end
        if (m_tmo) begin e_ird = BAD; e_tmo = 1; end
      end else if (m_owner == 2) begin
        e_addr = daddr; e_wdata = dwdata; e_be = dbyte_en; e_drd = ram_rdata;
        m_tmo = TMO_EN && m_dreq && ram_busy && (m_tcnt == TO);
        if (m_dreq) begin
          if (dwen) e_wen = 1; else e_ren = 1;
          if (!ram_busy || m_tmo) e_db = 0;
        end
        if (m_tmo) begin e_drd = BAD; e_tmo = 1; end
      end
    end
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("ram_byte_en", ram_byte_en, e_be);
    chk("ram_ren", ram_ren, e_ren);
    chk("ram_wen", ram_wen, e_wen);
    chk("ibusy", ibusy, e_ib);
    chk("dbusy", dbusy, e_db);
    chk("irdata", irdata, e_ird);
    chk("drdata", drdata, e_drd);
`ifdef RAM_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err, e_tmo);
`endif
    if (!nRST) begin
      m_owner = 0; m_gap = 0; m_pref_i = 1; m_tcnt = 0;
    end else if (m_owner == 0) begin
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_ireq && m_dreq) begin
        m_owner = m_pref_i ? 1 : 2;
        m_pref_i = !m_pref_i;
        m_tcnt = 0;
      end else if (m_ireq) begin
        m_owner = 1; m_pref_i = 0; m_tcnt = 0;
      end else if (m_dreq) begin
        m_owner = 2; m_pref_i = 1; m_tcnt = 0;
      end
    end else begin
      m_req = (m_owner == 1) ? m_ireq : m_dreq;
      if (!m_req) begin
        m_owner = 0; m_gap = 0;            // abort: straight back to idle
      end else if (!ram_busy || m_tmo) begin
        m_owner = 0; m_gap = 1;            // done: one release cycle first
      end else begin
        m_tcnt++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_i(input logic [12:0] a, output logic [31:0] d, output int ncyc);
    bit ok = 0;
    iren = 1; iaddr = a; d = '0; ncyc = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (!ibusy) begin ok = 1; d = irdata; ncyc = k; end
      step();
    end
    iren = 0;
    chk("i_completed", ok, 1);
  endtask

  task automatic run_d(input bit wr, input logic [12:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] d);
    bit ok = 0;
    dren = !wr; dwen = wr; daddr = a; dwdata = wd; dbyte_en = be; d = '0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (!dbusy) begin ok = 1; d = drdata; end
      step();
    end
    dren = 0; dwen = 0;
    chk("d_completed", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "global timeout");
  end

  logic [31:0] rd;
  int          ncyc, c0, n, dcyc, icyc, dzero, pulses, tc;
  int          order [0:3];

  initial begin
    iren = 0; dren = 0; dwen = 0; iaddr = '0; daddr = '0; dwdata = '0; dbyte_en = '0;
    #1 nRST = 0;
    #1;
    chk("rst_ibusy", ibusy, 1);
    chk("rst_dbusy", dbusy, 1);
    chk("rst_ram_ren", ram_ren, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_ram_addr", ram_addr, 0);
    step(); step();
    nRST = 1;
    step();

    // Single instruction read, zero latency
    lat = 0;
    run_i(13'h010, rd, ncyc);
    chk("t1_irdata", rd, 32'hDEADBEEF);
    chk("t1_done_cycle", ncyc, 1);
    step(); step();

    // Partial write, then read back
    lat = 2;
    c0 = wr_commits;
    run_d(1'b1, 13'h020, 32'h11223344, 4'b0011, rd);
    chk("t2_write_commits", wr_commits - c0, 1);
    step(); step();
    run_d(1'b0, 13'h020, 32'h0, 4'hF, rd);
    chk("t2_readback", rd, 32'hAAAA3344);
    step(); step();

    // Both requesting continuously from reset: alternating grants
    nRST = 0;
    @(negedge CLK);
    step();
    nRST = 1;
    lat = 1;
    iren = 1; iaddr = 13'h030; dren = 1; daddr = 13'h040; dbyte_en = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge CLK);
      if (!ibusy) begin
        order[n] = 1; n++;
        chk("t3_irdata", irdata, 32'hC0DE0030);
      end else if (!dbusy) begin
        order[n] = 2; n++;
        chk("t3_drdata", drdata, 32'hC0DE0040);
      end
      step();
    end
    iren = 0; dren = 0;
    chk("t3_completions", n, 4);
    chk("t3_order0", order[0], 1);
    chk("t3_order1", order[1], 2);
    chk("t3_order2", order[2], 1);
    chk("t3_order3", order[3], 2);
    step(); step(); step();

    // Instruction request arrives during a latency-3 data read
    lat = 3;
    dren = 1; daddr = 13'h050; iaddr = 13'h060;
    dcyc = -1; icyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) iren = 1;
      @(negedge CLK);
      if (c >= 1 && c <= 4) chk("t4_addr_hold", ram_addr, 13'h050);
      if (!dbusy && dcyc < 0) dcyc = c;
      if (!ibusy && icyc < 0) icyc = c;
      step();
      if (dcyc >= 0) dren = 0;
      if (icyc >= 0) iren = 0;
    end
    chk("t4_d_done_cycle", dcyc, 4);
    chk("t4_i_done_cycle", icyc, 10);
    step(); step();

    // Data read aborted two cycles into a latency-5 grant
    lat = 5;
    dren = 1; daddr = 13'h070;
    dzero = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) dren = 0;
      @(negedge CLK);
      if (c == 2) chk("t5_ren_in_grant", ram_ren, 1);
      if (c == 3) chk("t5_ren_on_abort", ram_ren, 0);
      if (!dbusy) dzero++;
      step();
    end
    chk("t5_dbusy_never_low", dzero, 0);

    // Reset pulse during a data write
    dwen = 1; daddr = 13'h080; dwdata = 32'h55555555; dbyte_en = 4'hF;
    step(); step();
    chk("t6_wen_before_reset", ram_wen, 1);
    #2 nRST = 0;
    #1;
    chk("t6_rst_wen", ram_wen, 0);
    chk("t6_rst_ren", ram_ren, 0);
    chk("t6_rst_dbusy", dbusy, 1);
    chk("t6_rst_ibusy", ibusy, 1);
    chk("t6_rst_addr", ram_addr, 0);
    chk("t6_rst_wdata", ram_wdata, 0);
    chk("t6_rst_byte_en", ram_byte_en, 0);
    dwen = 0;
    step();
    nRST = 1;
    step(); step();

`ifdef RAM_ARB_TIMEOUT_EN
    // RAM never finishes: watchdog ends the data read
    lat = 0; force_busy = 1;
    dren = 1; daddr = 13'h090;
    tc = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (timeout_err) pulses++;
      if (!dbusy && tc < 0) begin
        tc = c;
        chk("t7_bad_data", drdata, BAD);
      end
      step();
      if (tc >= 0) begin dren = 0; force_busy = 0; end
    end
    chk("t7_timeout_cycle", tc, 9);
    chk("t7_err_pulses", pulses, 1);
    run_i(13'h010, rd, ncyc);
    chk("t7_recover_irdata", rd, 32'hDEADBEEF);
    step(); step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
